// File: rtl/podule_cycle.sv
// Podule bus-cycle sequencer: decodes host requests, runs timed
// setup/strobe/hold cycles to external devices, hosts page latch and irq status.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   a[11:0]                    host address bits [13:2]
//   host_rd, host_wr           level requests (exactly one accepted)
//   host_wdata, host_rdata     host data; rdata valid with host_ack
//   host_ack, host_busy        completion pulse, in-progress flag
//   dev_cs_n[4:0]              selects {uart, ide, eth, econet, rom}
//   dev_rd_n, dev_wr_n         device strobes
//   dev_din, dev_dout, dev_oe  device data in/out and drive enable
//   irq[3:0]                   {uart, ide, ethernet, econet}
//   flash_page[7:0]            flash page latch
module podule_cycle #(
    parameter int unsigned SETUP    = 1,
    parameter int unsigned HOLD     = 1,
    parameter int unsigned ROM_STB  = 4,
    parameter int unsigned ECO_STB  = 8,
    parameter int unsigned ETH_STB  = 3,
    parameter int unsigned IDE_STB  = 6,
    parameter int unsigned UART_STB = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] a,
    input  logic        host_rd,
    input  logic        host_wr,
    input  logic [15:0] host_wdata,
    output logic [15:0] host_rdata,
    output logic        host_ack,
    output logic        host_busy,
    output logic [4:0]  dev_cs_n,
    output logic        dev_rd_n,
    output logic        dev_wr_n,
    input  logic [15:0] dev_din,
    output logic [15:0] dev_dout,
    output logic        dev_oe,
    input  logic [3:0]  irq,
    output logic [7:0]  flash_page
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE, S_WAITREL
    } state_t;

    // External regions first so the enum value is the select bit index.
    typedef enum logic [2:0] {
        R_ROM, R_ECO, R_ETH, R_IDE, R_UART, R_IRQ, R_PAGE, R_NONE
    } region_t;

    localparam logic [3:0] SETUP_LD = (SETUP == 0) ? 4'd0 : 4'(SETUP - 1);
    localparam logic [3:0] HOLD_LD  = (HOLD == 0) ? 4'd0 : 4'(HOLD - 1);

    function automatic region_t decode(input logic [11:0] addr);
        region_t r;
        if (!addr[11]) begin
            r = R_ROM;
        end else begin
            case (addr[10:8])
                3'b000:  r = R_ECO;
                3'b001:  r = R_ETH;
                3'b010:  r = R_IDE;
                3'b011:  r = R_IRQ;
                3'b100:  r = R_PAGE;
                3'b101:  r = R_UART;
                default: r = R_NONE;
            endcase
        end
        return r;
    endfunction

    // Counter holds remaining cycles minus one; a zero strobe acts as one.
    function automatic logic [3:0] stb_load(input region_t r);
        int unsigned n;
        case (r)
            R_ROM:   n = ROM_STB;
            R_ECO:   n = ECO_STB;
            R_ETH:   n = ETH_STB;
            R_IDE:   n = IDE_STB;
            R_UART:  n = UART_STB;
            default: n = 1;
        endcase
        if (n == 0) n = 1;
        return 4'(n - 1);
    endfunction

    state_t      state, state_n;
    region_t     region_q, region_in, region_cur;
    logic [3:0]  cnt, cnt_n;
    logic        wr_q, wr_cur;
    logic        req_ok, accept, is_ext, active_n;
    logic [4:0]  cs_n_nxt;
    logic        rd_n_nxt, wr_n_nxt;

    always_comb begin
        region_in  = decode(a);
        req_ok     = host_rd ^ host_wr;
        accept     = (state == S_IDLE) && req_ok;
        is_ext     = region_in inside {R_ROM, R_ECO, R_ETH, R_IDE, R_UART};
        region_cur = (state == S_IDLE) ? region_in : region_q;
        wr_cur     = (state == S_IDLE) ? host_wr : wr_q;
        state_n    = state;
        cnt_n      = cnt;
        unique case (state)
            S_IDLE: begin
                if (req_ok) begin
                    if (!is_ext) begin
                        state_n = S_DONE;
                    end else if (SETUP != 0) begin
                        state_n = S_SETUP;
                        cnt_n   = SETUP_LD;
                    end else begin
                        state_n = S_STROBE;
                        cnt_n   = stb_load(region_in);
                    end
                end
            end
            S_SETUP: begin
                if (cnt == 4'd0) begin
                    state_n = S_STROBE;
                    cnt_n   = stb_load(region_q);
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt == 4'd0) begin
                    if (HOLD != 0) begin
                        state_n = S_HOLD;
                        cnt_n   = HOLD_LD;
                    end else begin
                        state_n = S_DONE;
                    end
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (cnt == 4'd0) state_n = S_DONE;
                else             cnt_n   = cnt - 4'd1;
            end
            S_DONE:    state_n = S_WAITREL;
            S_WAITREL: if (!host_rd && !host_wr) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
        active_n = state_n inside {S_SETUP, S_STROBE, S_HOLD};
        cs_n_nxt = active_n ? ~(5'b00001 << region_cur) : 5'b11111;
        rd_n_nxt = !((state_n == S_STROBE) && !wr_cur);
        wr_n_nxt = !((state_n == S_STROBE) && wr_cur);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            region_q   <= R_ROM;
            wr_q       <= 1'b0;
            dev_cs_n   <= 5'b11111;
            dev_rd_n   <= 1'b1;
            dev_wr_n   <= 1'b1;
            dev_oe     <= 1'b0;
            dev_dout   <= 16'h0000;
            host_ack   <= 1'b0;
            host_busy  <= 1'b0;
            host_rdata <= 16'h0000;
            flash_page <= 8'h00;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            dev_cs_n  <= cs_n_nxt;
            dev_rd_n  <= rd_n_nxt;
            dev_wr_n  <= wr_n_nxt;
            dev_oe    <= active_n && wr_cur;
            host_ack  <= (state_n == S_DONE);
            host_busy <= active_n;
            if (accept) begin
                region_q <= region_in;
                wr_q     <= host_wr;
                if (host_wr && is_ext) dev_dout <= host_wdata;
                case (region_in)
                    R_PAGE: begin
                        if (host_wr) flash_page <= host_wdata[7:0];
                        else         host_rdata <= {8'h00, flash_page};
                    end
                    R_IRQ:   if (!host_wr) host_rdata <= {12'h000, irq};
                    R_NONE:  if (!host_wr) host_rdata <= 16'hFFFF;
                    default: ;
                endcase
            end
            // Capture on the final strobe cycle, while the device still drives.
            if (state == S_STROBE && cnt == 4'd0 && !wr_q)
                host_rdata <= dev_din;
        end
    end

endmodule

// File: tb/tb_podule_cycle.sv
// Self-checking bench for podule_cycle: table vectors, corner-case
// sequences and randomized requests against a region-level reference model.
module tb_podule_cycle;

    localparam int SETUP    = 1;
    localparam int HOLD     = 1;
    localparam int ROM_STB  = 4;
    localparam int ECO_STB  = 8;
    localparam int ETH_STB  = 3;
    localparam int IDE_STB  = 6;
    localparam int UART_STB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] a;
    logic        host_rd, host_wr;
    logic [15:0] host_wdata, host_rdata;
    logic        host_ack, host_busy;
    logic [4:0]  dev_cs_n;
    logic        dev_rd_n, dev_wr_n;
    logic [15:0] dev_din, dev_dout;
    logic        dev_oe;
    logic [3:0]  irq;
    logic [7:0]  flash_page;

    podule_cycle #(
        .SETUP(SETUP), .HOLD(HOLD), .ROM_STB(ROM_STB), .ECO_STB(ECO_STB),
        .ETH_STB(ETH_STB), .IDE_STB(IDE_STB), .UART_STB(UART_STB)
    ) dut (
        .clk(clk), .rst(rst), .a(a), .host_rd(host_rd), .host_wr(host_wr),
        .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_ack(host_ack), .host_busy(host_busy), .dev_cs_n(dev_cs_n),
        .dev_rd_n(dev_rd_n), .dev_wr_n(dev_wr_n), .dev_din(dev_din),
        .dev_dout(dev_dout), .dev_oe(dev_oe), .irq(irq),
        .flash_page(flash_page)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  cs_mask;
        int          cs_cyc;
        int          rd_cyc;
        int          wr_cyc;
        int          lat;
        logic        chk_rd;
        logic [15:0] rdata;
        logic [7:0]  page;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [11:0] addr;
        logic [15:0] wd;
        logic [15:0] din;
        logic [3:0]  irqv;
        exp_t        e;
    } vec_t;

    typedef struct {
        logic [4:0]  cs_mask;
        int          cs_cyc;
        int          rd_cyc;
        int          wr_cyc;
        int          ack_cnt;
        int          lat;
        int          busy_cyc;
        int          oe_cyc;
        int          dout_bad;
        logic [15:0] rdata;
    } obs_t;

    int vectors = 0;
    int miscompares = 0;
    int proto_bad = 0;
    logic [7:0] page_model;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(~dev_cs_n) > 1) proto_bad++;
            if (!dev_rd_n && !dev_wr_n) proto_bad++;
        end
    end

    // Reference: cycle shape per region from the timing rules.
    function automatic exp_t model(input vec_t v, input logic [7:0] page);
        exp_t e;
        int   b;
        int   stb;
        int   s;
        b   = -1;
        stb = 1;
        e.cs_mask = 5'b0;
        e.cs_cyc  = 0;
        e.rd_cyc  = 0;
        e.wr_cyc  = 0;
        e.lat     = 1;
        e.chk_rd  = v.rd;
        e.rdata   = 16'hFFFF;
        e.page    = page;
        if (!v.addr[11]) begin
            b = 0; stb = ROM_STB;
        end else begin
            case (v.addr[11:8])
                4'h8: begin b = 1; stb = ECO_STB;  end
                4'h9: begin b = 2; stb = ETH_STB;  end
                4'hA: begin b = 3; stb = IDE_STB;  end
                4'hD: begin b = 4; stb = UART_STB; end
                default: b = -1;
            endcase
        end
        if (b >= 0) begin
            s         = (stb == 0) ? 1 : stb;
            e.cs_mask = 5'(1 << b);
            e.cs_cyc  = SETUP + s + HOLD;
            e.rd_cyc  = v.rd ? s : 0;
            e.wr_cyc  = v.wr ? s : 0;
            e.lat     = e.cs_cyc + 1;
            e.rdata   = v.din;
        end else begin
            case (v.addr[11:8])
                4'hB: e.rdata = {12'h000, v.irqv};
                4'hC: begin
                    e.rdata = {8'h00, page};
                    if (v.wr) e.page = v.wd[7:0];
                end
                default: e.rdata = 16'hFFFF;
            endcase
        end
        return e;
    endfunction

    task automatic run(input vec_t v, output obs_t o);
        o.cs_mask = 5'b0;
        o.cs_cyc = 0; o.rd_cyc = 0; o.wr_cyc = 0; o.ack_cnt = 0;
        o.lat = 0; o.busy_cyc = 0; o.oe_cyc = 0; o.dout_bad = 0;
        o.rdata = 16'h0;
        a = v.addr; host_wdata = v.wd; dev_din = v.din; irq = v.irqv;
        host_rd = v.rd; host_wr = v.wr;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (dev_cs_n != 5'b11111) begin
                o.cs_cyc++;
                o.cs_mask = o.cs_mask | ~dev_cs_n;
            end
            if (!dev_rd_n) o.rd_cyc++;
            if (!dev_wr_n) o.wr_cyc++;
            if (host_busy) o.busy_cyc++;
            if (dev_oe) begin
                o.oe_cyc++;
                if (dev_dout !== v.wd) o.dout_bad++;
            end
            if (host_ack) begin
                o.ack_cnt++;
                if (o.lat == 0) begin
                    o.lat = k; o.rdata = host_rdata;
                    host_rd = 1'b0; host_wr = 1'b0;
                end
            end
            if (o.lat != 0 && k >= o.lat + 3) break;
        end
        host_rd = 1'b0; host_wr = 1'b0;
    endtask

    task automatic compare(input string t, input vec_t v, input obs_t o,
                           input exp_t e);
        check($sformatf("%s cs_mask", t), o.cs_mask, e.cs_mask);
        check($sformatf("%s cs_cyc", t), o.cs_cyc, e.cs_cyc);
        check($sformatf("%s rd_cyc", t), o.rd_cyc, e.rd_cyc);
        check($sformatf("%s wr_cyc", t), o.wr_cyc, e.wr_cyc);
        check($sformatf("%s acks", t), o.ack_cnt, 1);
        check($sformatf("%s latency", t), o.lat, e.lat);
        check($sformatf("%s busy_cyc", t), o.busy_cyc, e.cs_cyc);
        check($sformatf("%s oe_cyc", t), o.oe_cyc, v.wr ? e.cs_cyc : 0);
        check($sformatf("%s dout_bad", t), o.dout_bad, 0);
        if (e.chk_rd) check($sformatf("%s rdata", t), o.rdata, e.rdata);
        check($sformatf("%s page", t), flash_page, e.page);
    endtask

    vec_t tbl[12];
    vec_t v;
    obs_t o;
    exp_t e;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 12'h010, 16'h0000, 16'hA55A, 4'h0,
                    '{5'b00001, 6, 4, 0, 7, 1'b1, 16'hA55A, 8'h00}};
        tbl[1]  = '{1'b0, 1'b1, 12'h900, 16'h1234, 16'h0000, 4'h0,
                    '{5'b00100, 5, 0, 3, 6, 1'b0, 16'h0000, 8'h00}};
        tbl[2]  = '{1'b0, 1'b1, 12'hC00, 16'h005C, 16'h0000, 4'h0,
                    '{5'b00000, 0, 0, 0, 1, 1'b0, 16'h0000, 8'h5C}};
        tbl[3]  = '{1'b1, 1'b0, 12'hC00, 16'h0000, 16'h0000, 4'h0,
                    '{5'b00000, 0, 0, 0, 1, 1'b1, 16'h005C, 8'h5C}};
        tbl[4]  = '{1'b1, 1'b0, 12'hB00, 16'h0000, 16'h0000, 4'b1010,
                    '{5'b00000, 0, 0, 0, 1, 1'b1, 16'h000A, 8'h5C}};
        tbl[5]  = '{1'b1, 1'b0, 12'hE00, 16'h0000, 16'h0000, 4'h0,
                    '{5'b00000, 0, 0, 0, 1, 1'b1, 16'hFFFF, 8'h5C}};
        tbl[6]  = '{1'b0, 1'b1, 12'hB00, 16'hFFFF, 16'h0000, 4'h3,
                    '{5'b00000, 0, 0, 0, 1, 1'b0, 16'h0000, 8'h5C}};
        tbl[7]  = '{1'b0, 1'b1, 12'hF00, 16'h0077, 16'h0000, 4'h0,
                    '{5'b00000, 0, 0, 0, 1, 1'b0, 16'h0000, 8'h5C}};
        tbl[8]  = '{1'b1, 1'b0, 12'h800, 16'h0000, 16'h1111, 4'h0,
                    '{5'b00010, 10, 8, 0, 11, 1'b1, 16'h1111, 8'h5C}};
        tbl[9]  = '{1'b0, 1'b1, 12'hA04, 16'hBEEF, 16'h0000, 4'h0,
                    '{5'b01000, 8, 0, 6, 9, 1'b0, 16'h0000, 8'h5C}};
        tbl[10] = '{1'b1, 1'b0, 12'hD00, 16'h0000, 16'h0F0F, 4'h0,
                    '{5'b10000, 10, 8, 0, 11, 1'b1, 16'h0F0F, 8'h5C}};
        tbl[11] = '{1'b0, 1'b1, 12'h3FF, 16'hC0DE, 16'h0000, 4'h0,
                    '{5'b00001, 6, 0, 4, 7, 1'b0, 16'h0000, 8'h5C}};

        rst = 1'b1; a = 12'h0; host_rd = 1'b0; host_wr = 1'b0;
        host_wdata = 16'h0; dev_din = 16'h0; irq = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst cs_n", dev_cs_n, 5'b11111);
        check("rst rd_n", dev_rd_n, 1'b1);
        check("rst wr_n", dev_wr_n, 1'b1);
        check("rst oe", dev_oe, 1'b0);
        check("rst dout", dev_dout, 16'h0);
        check("rst ack", host_ack, 1'b0);
        check("rst busy", host_busy, 1'b0);
        check("rst rdata", host_rdata, 16'h0);
        check("rst page", flash_page, 8'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run(tbl[i], o);
            compare($sformatf("vec%0d", i), tbl[i], o, tbl[i].e);
        end
        page_model = 8'h5C;

        // UART read held well past completion: one cycle only.
        begin
            int rdc, csc, ackc;
            logic [15:0] rdv;
            rdc = 0; csc = 0; ackc = 0; rdv = 16'h0;
            a = 12'hD00; dev_din = 16'h5AA5; host_rd = 1'b1;
            for (int k = 0; k < 34; k++) begin
                if (k == 30) host_rd = 1'b0;
                @(posedge clk); #1;
                if (!dev_rd_n) rdc++;
                if (dev_cs_n != 5'b11111) csc++;
                if (host_ack) begin ackc++; rdv = host_rdata; end
            end
            check("held rd_cyc", rdc, 8);
            check("held cs_cyc", csc, 10);
            check("held acks", ackc, 1);
            check("held rdata", rdv, 16'h5AA5);
        end

        // Both requests high: nothing accepted.
        begin
            int act;
            act = 0;
            a = 12'h010; host_rd = 1'b1; host_wr = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                if (dev_cs_n != 5'b11111 || !dev_rd_n || !dev_wr_n ||
                    host_ack || host_busy || dev_oe) act++;
            end
            host_rd = 1'b0; host_wr = 1'b0;
            check("both_hi activity", act, 0);
            repeat (2) @(posedge clk);
            #1;
        end

        // Reset during the IDE strobe phase.
        begin
            int n;
            n = 0;
            a = 12'hA00; dev_din = 16'h4321; host_rd = 1'b1;
            while (dev_rd_n && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("ide strobe seen", dev_rd_n, 1'b0);
            @(posedge clk); #1;
            rst = 1'b1; host_rd = 1'b0;
            @(posedge clk); #1;
            check("midrst cs_n", dev_cs_n, 5'b11111);
            check("midrst rd_n", dev_rd_n, 1'b1);
            check("midrst wr_n", dev_wr_n, 1'b1);
            check("midrst ack", host_ack, 1'b0);
            check("midrst busy", host_busy, 1'b0);
            rst = 1'b0;
            page_model = 8'h00;
            run(tbl[0], o);
            compare("post_rst", tbl[0], o, tbl[0].e);
        end

        for (int i = 0; i < 60; i++) begin
            v.rd   = 1'($urandom_range(0, 1));
            v.wr   = !v.rd;
            v.addr = 12'($urandom);
            v.wd   = 16'($urandom);
            v.din  = 16'($urandom);
            v.irqv = 4'($urandom);
            e = model(v, page_model);
            v.e = e;
            page_model = e.page;
            run(v, o);
            compare($sformatf("rnd%0d", i), v, o, e);
        end

        check("protocol", proto_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
